// File: rtl/rgb_pwm_pkg.sv
// Shared constants and duty-bus typing for the RGB PWM block and the colour-fade stage.
// Keeping the width derivation here stops the two stages' duty buses from diverging.
package rgb_pwm_pkg;

  localparam int unsigned PwmIntervalDefault = 1200;

  // Counter/duty width for a given period; a 1-cycle period still needs one bit.
  function automatic int unsigned duty_width(input int unsigned interval);
    return (interval > 2) ? $clog2(interval) : 1;
  endfunction

  typedef logic [duty_width(PwmIntervalDefault)-1:0] duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: boundary-loaded shadow duty, compare against the shared counter,
// and a registered LED drive with optional inversion for common-anode LEDs.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PwmIntervalDefault,
  parameter bit          ACTIVE_LOW   = 1'b1,
  localparam int unsigned W           = duty_width(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  input  logic         load,
  input  logic [W-1:0] duty,
  output logic         led
);

  logic [W-1:0] sh_q;
  logic         active;
  logic         led_q;

  // Duties at or above the period length compare true on every count: 100 % on.
  always_comb begin
    active = (cnt < sh_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      led_q <= ACTIVE_LOW;
    end else begin
      if (load) begin
        sh_q <= duty;
      end
      led_q <= active ^ ACTIVE_LOW;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel phase-aligned PWM generator with a period-boundary strobe.
// The top holds only the shared period counter, its wrap decode and the strobe flop.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PwmIntervalDefault,
  parameter bit          ACTIVE_LOW   = 1'b1,
  localparam int unsigned W           = duty_width(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] duty_r,
  input  logic [W-1:0] duty_g,
  input  logic [W-1:0] duty_b,
  output logic         led_r,
  output logic         led_g,
  output logic         led_b,
  output logic         period_start
);

  localparam logic [W-1:0] CntLast = W'(PWM_INTERVAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         load;
  logic         period_start_q;

  always_comb begin
    load  = (cnt_q == CntLast);
    cnt_d = load ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= load;
    end
  end

  assign period_start = period_start_q;

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_ch_r (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .load (load),
    .duty (duty_r),
    .led  (led_r)
  );

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_ch_g (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .load (load),
    .duty (duty_g),
    .led  (led_g)
  );

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_ch_b (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .load (load),
    .duty (duty_b),
    .led  (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm.sv
// Bench for rgb_pwm: an 8-cycle active-low unit, an 8-cycle active-high twin on the same
// duties, and a 10-cycle unit whose 4-bit duties can express full and out-of-range values.
module tb_rgb_pwm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] d8r = '0, d8g = '0, d8b = '0;
  logic [3:0] d10r = '0, d10g = '0, d10b = '0;

  logic a_r, a_g, a_b, a_ps;
  logic h_r, h_g, h_b, h_ps;
  logic c_r, c_g, c_b, c_ps;

  always #5 clk = ~clk;

  rgb_pwm #(.PWM_INTERVAL(8), .ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .duty_r(d8r), .duty_g(d8g), .duty_b(d8b),
    .led_r(a_r), .led_g(a_g), .led_b(a_b), .period_start(a_ps)
  );

  rgb_pwm #(.PWM_INTERVAL(8), .ACTIVE_LOW(1'b0)) u_h (
    .clk(clk), .rst(rst), .duty_r(d8r), .duty_g(d8g), .duty_b(d8b),
    .led_r(h_r), .led_g(h_g), .led_b(h_b), .period_start(h_ps)
  );

  rgb_pwm #(.PWM_INTERVAL(10), .ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst(rst), .duty_r(d10r), .duty_g(d10g), .duty_b(d10b),
    .led_r(c_r), .led_g(c_g), .led_b(c_b), .period_start(c_ps)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] h;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  // Reference state: phase = counter value in the current cycle, cur = duty in force this
  // period, prev = duty of the period before (needed for the cycle right after a wrap).
  int unsigned ph8, ph10;
  int unsigned cur8[3], prev8[3], cur10[3], prev10[3];
  bit wr8, wr10;

  // LED state in the cycle whose counter reads ph: it reflects the compare one cycle earlier.
  function automatic logic on_bit(int unsigned n, int unsigned ph, int unsigned prv,
                                  int unsigned cur);
    return (ph == 0) ? ((n - 1) < prv) : ((ph - 1) < cur);
  endfunction

  task automatic model_reset();
    ph8 = 0;
    ph10 = 0;
    wr8 = 1'b0;
    wr10 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cur8[k] = 0; prev8[k] = 0; cur10[k] = 0; prev10[k] = 0;
    end
  endtask

  // Predict the cycle after the next edge from the duties being presented, then clock.
  task automatic tick();
    exp_t e;
    logic [2:0] o8, o10;
    if (ph8 == 7) begin
      prev8 = cur8;
      cur8[0] = d8r; cur8[1] = d8g; cur8[2] = d8b;
      wr8 = 1'b1;
    end
    if (ph10 == 9) begin
      prev10 = cur10;
      cur10[0] = d10r; cur10[1] = d10g; cur10[2] = d10b;
      wr10 = 1'b1;
    end
    ph8 = (ph8 + 1) % 8;
    ph10 = (ph10 + 1) % 10;
    for (int k = 0; k < 3; k++) begin
      o8[2-k]  = on_bit(8, ph8, prev8[k], cur8[k]);
      o10[2-k] = on_bit(10, ph10, prev10[k], cur10[k]);
    end
    e.a = {~o8, wr8 && (ph8 == 0)};
    e.h = {o8, wr8 && (ph8 == 0)};
    e.c = {~o10, wr10 && (ph10 == 0)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    d8r = 3'd3; d8g = 3'd5; d8b = 3'd1;
    d10r = 4'd0; d10g = 4'd10; d10b = 4'd15;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({a_r, a_g, a_b, a_ps} !== 4'b1110)
        $display("FAIL reset_hold_a cyc %0d got %b want 1110", i, {a_r, a_g, a_b, a_ps});
      else passed++;
      total++;
      if ({h_r, h_g, h_b, h_ps} !== 4'b0000)
        $display("FAIL reset_hold_h cyc %0d got %b want 0000", i, {h_r, h_g, h_b, h_ps});
      else passed++;
      total++;
      if ({c_r, c_g, c_b, c_ps} !== 4'b1110)
        $display("FAIL reset_hold_c cyc %0d got %b want 1110", i, {c_r, c_g, c_b, c_ps});
      else passed++;
    end
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({a_r, a_g, a_b, a_ps} !== e.a)
        $display("FAIL reset_release_a cyc %0d got %b want %b", i, {a_r, a_g, a_b, a_ps}, e.a);
      else passed++;
      total++;
      if ({h_r, h_g, h_b, h_ps} !== e.h)
        $display("FAIL reset_release_h cyc %0d got %b want %b", i, {h_r, h_g, h_b, h_ps}, e.h);
      else passed++;
      total++;
      if ({c_r, c_g, c_b, c_ps} !== e.c)
        $display("FAIL reset_release_c cyc %0d got %b want %b", i, {c_r, c_g, c_b, c_ps}, e.c);
      else passed++;
    end
  endtask

  task automatic test_steady();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({a_r, a_g, a_b, a_ps} !== e.a)
        $display("FAIL steady_a cyc %0d got %b want %b", i, {a_r, a_g, a_b, a_ps}, e.a);
      else passed++;
      total++;
      if ({h_r, h_g, h_b, h_ps} !== e.h)
        $display("FAIL steady_h cyc %0d got %b want %b", i, {h_r, h_g, h_b, h_ps}, e.h);
      else passed++;
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    d8r = 3'd0; d8g = 3'd7; d8b = 3'd0;
    for (int i = 0; i < 30; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({a_r, a_g, a_b, a_ps} !== e.a)
        $display("FAIL extremes_a cyc %0d got %b want %b", i, {a_r, a_g, a_b, a_ps}, e.a);
      else passed++;
      total++;
      if ({c_r, c_g, c_b, c_ps} !== e.c)
        $display("FAIL extremes_c cyc %0d got %b want %b", i, {c_r, c_g, c_b, c_ps}, e.c);
      else passed++;
    end
  endtask

  // Stage 0: wait for duty 2 in force at cnt 4 and request 6; stage 1: at cnt 3 of the
  // duty-6 period glitch to 1; stage 2: restore 6 at cnt 5; stage 3: observe two periods.
  task automatic test_glitch_free();
    exp_t e;
    bit hit;
    d8r = 3'd2;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 30; i++) begin
        hit = (s == 0 && ph8 == 4 && cur8[0] == 2) || (s == 1 && ph8 == 3 && cur8[0] == 6) ||
              (s == 2 && ph8 == 5) || (s == 3 && i == 16);
        if (hit) break;
        tick();
        e = sb.pop_front();
        total++;
        if ({a_r, a_g, a_b, a_ps} !== e.a)
          $display("FAIL glitch_a stage %0d cyc %0d got %b want %b", s, i,
                   {a_r, a_g, a_b, a_ps}, e.a);
        else passed++;
      end
      case (s)
        0: d8r = 3'd6;
        1: d8r = 3'd1;
        2: d8r = 3'd6;
        default: ;
      endcase
    end
  endtask

  task automatic test_polarity();
    exp_t e;
    d8r = 3'd3; d8g = 3'd3; d8b = 3'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({h_r, h_g, h_b, h_ps} !== e.h)
        $display("FAIL polarity_h cyc %0d got %b want %b", i, {h_r, h_g, h_b, h_ps}, e.h);
      else passed++;
      total++;
      if ({h_r, h_g, h_b} !== ~{a_r, a_g, a_b})
        $display("FAIL polarity_complement cyc %0d got %b want %b", i, {h_r, h_g, h_b},
                 ~{a_r, a_g, a_b});
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    d8r = 3'd7; d8g = 3'd7; d8b = 3'd7;
    for (int i = 0; i < 30; i++) begin
      if (ph8 == 5 && cur8[0] == 7) break;
      tick();
      e = sb.pop_front();
      total++;
      if ({a_r, a_g, a_b, a_ps} !== e.a)
        $display("FAIL async_pre_a cyc %0d got %b want %b", i, {a_r, a_g, a_b, a_ps}, e.a);
      else passed++;
    end
    // Assert between edges: the outputs must drop without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_r, a_g, a_b, a_ps} !== 4'b1110)
      $display("FAIL async_assert_a got %b want 1110", {a_r, a_g, a_b, a_ps});
    else passed++;
    total++;
    if ({h_r, h_g, h_b, h_ps} !== 4'b0000)
      $display("FAIL async_assert_h got %b want 0000", {h_r, h_g, h_b, h_ps});
    else passed++;
    total++;
    if ({c_r, c_g, c_b, c_ps} !== 4'b1110)
      $display("FAIL async_assert_c got %b want 1110", {c_r, c_g, c_b, c_ps});
    else passed++;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({a_r, a_g, a_b, a_ps} !== e.a)
        $display("FAIL async_post_a cyc %0d got %b want %b", i, {a_r, a_g, a_b, a_ps}, e.a);
      else passed++;
      total++;
      if ({c_r, c_g, c_b, c_ps} !== e.c)
        $display("FAIL async_post_c cyc %0d got %b want %b", i, {c_r, c_g, c_b, c_ps}, e.c);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_glitch_free();
    test_polarity();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
